// File: rtl/grid_arb_pkg.sv
// Shared definitions for the grid RAM access arbiter: op codes, free-cell
// marker, FSM state encoding and the cell address helper.
package grid_arb_pkg;

  localparam logic [1:0] OP_RD    = 2'b00;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_CLAIM = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [31:0] GRID_EMPTY = 32'hFFFF_FFFF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  // Row-major linear address; callers truncate to their address width.
  function automatic longint cell_addr(input longint x, input longint y, input longint n);
    return x * n + y;
  endfunction

endpackage

// File: rtl/grid_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; the pointer moves past the winner when advance is asserted.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  int            idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && |req) begin
      ptr <= PW'((int'(gidx) + 1) % N_REQ);
    end
  end

endmodule

// File: rtl/grid_access_arbiter.sv
// Shares one grid RAM between N_REQ requesters: bounds-checked read, write
// and atomic claim (test-for-EMPTY then write) under round-robin arbitration.
module grid_access_arbiter
  import grid_arb_pkg::*;
#(
  parameter int             N_REQ = 2,
  parameter int             N     = 9,
  parameter int             DW    = 32,
  parameter logic [DW-1:0]  EMPTY = DW'(GRID_EMPTY)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [2*N_REQ-1:0]  req_op,
  input  logic [DW*N_REQ-1:0] req_x,
  input  logic [DW*N_REQ-1:0] req_y,
  input  logic [DW*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic                rsp_ok,
  output logic [DW-1:0]       rsp_data,
  output logic                busy,
  output logic [15:0]         claim_fail_cnt,
  output logic                mem_re,
  output logic                mem_we,
  output logic [DW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_din,
  input  logic [DW-1:0]       mem_dout
);

  localparam int                    PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic signed [DW-1:0]  NLIM = DW'(N);

  logic [2:0]              state;
  logic [N_REQ-1:0]        grant;
  logic [PW-1:0]           gid;
  logic [1:0]              gop;
  logic signed [DW-1:0]    gx;
  logic signed [DW-1:0]    gy;
  logic [DW-1:0]           gdata;
  logic [DW-1:0]           gaddr;
  logic                    oob;

  logic [PW-1:0]           id_q;
  logic [1:0]              op_q;
  logic [DW-1:0]           data_q;
  logic [DW-1:0]           cell_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (state == S_IDLE),
    .grant   (grant)
  );

  always_comb begin
    gid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gid = PW'(i);
    end
  end

  assign gop   = req_op[2*gid +: 2];
  assign gx    = $signed(req_x[DW*gid +: DW]);
  assign gy    = $signed(req_y[DW*gid +: DW]);
  assign gdata = req_data[DW*gid +: DW];
  assign oob   = gx[DW-1] || (gx >= NLIM) || gy[DW-1] || (gy >= NLIM);
  assign gaddr = DW'(cell_addr(longint'(gx), longint'(gy), longint'(N)));

  // Operand and read-data registers carry no reset; they are always written
  // before the FSM consumes them.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && |req) begin
      id_q   <= gid;
      op_q   <= gop;
      data_q <= gdata;
    end
    if (state == S_WAIT) begin
      cell_q <= mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      ack            <= '0;
      rsp_ok         <= 1'b0;
      rsp_data       <= '0;
      mem_re         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
      claim_fail_cnt <= '0;
    end else begin
      ack    <= '0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            busy <= 1'b1;
            if (oob || gop == OP_RSVD) begin
              rsp_ok   <= 1'b0;
              rsp_data <= EMPTY;
              ack      <= grant;
              state    <= S_RESP;
            end else if (gop == OP_WR) begin
              mem_we   <= 1'b1;
              mem_addr <= gaddr;
              mem_din  <= gdata;
              rsp_ok   <= 1'b1;
              rsp_data <= gdata;
              state    <= S_WR;
            end else begin
              mem_re   <= 1'b1;
              mem_addr <= gaddr;
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  state <= S_EVAL;
        S_EVAL: begin
          // Claim write follows its read with no IDLE in between, so no
          // other requester can be granted in the gap.
          if (op_q == OP_CLAIM && cell_q == EMPTY) begin
            mem_we   <= 1'b1;
            mem_din  <= data_q;
            rsp_ok   <= 1'b1;
            rsp_data <= data_q;
            state    <= S_WR;
          end else begin
            rsp_data    <= cell_q;
            rsp_ok      <= (op_q != OP_CLAIM);
            ack[id_q]   <= 1'b1;
            state       <= S_RESP;
            if (op_q == OP_CLAIM && claim_fail_cnt != 16'hFFFF) begin
              claim_fail_cnt <= claim_fail_cnt + 16'd1;
            end
          end
        end
        S_WR: begin
          ack[id_q] <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
